// File: rtl/clk_div_pkg.sv
// Shared constants, state encoding and helpers for the multi-channel divider.
// Optional feature macro: CLKDIV_GLITCHFREE_EN (see clk_div_chan).
package clk_div_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int DIV_MIN   = 2;

  typedef enum logic {DIS = 1'b0, RUN = 1'b1} chan_state_t;

  // Length of the high phase; odd divisors keep the extra cycle high.
  function automatic logic [31:0] calc_hi(input logic [31:0] div);
    return div - (div >> 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: DIS/RUN FSM, period counter, registered clk_out/tick.
// CLKDIV_GLITCHFREE_EN: divisor updates wait in a pending register until the
// period wraps; otherwise an update takes effect at once and restarts the period.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int                DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0]  DIV_RST = DIV_W'(5208)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             ready,
  output logic             clk_out,
  output logic             tick
);

  chan_state_t      state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt, div, div_nxt;
  logic             clk_nxt, tick_nxt;
  logic             run_ok, last;
  logic [31:0]      hi;

  assign run_ok = en && (div >= DIV_W'(DIV_MIN));
  assign last   = (cnt == div - DIV_W'(1));
  assign hi     = calc_hi(32'(div));

`ifdef CLKDIV_GLITCHFREE_EN
  logic             pvld, pvld_nxt;
  logic [DIV_W-1:0] pdiv, pdiv_nxt;

  assign ready = !pvld;

  // Pending divisor register, applied at wrap or while disabled.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pvld <= 1'b0;
      pdiv <= '0;
    end else begin
      pvld <= pvld_nxt;
      pdiv <= pdiv_nxt;
    end
  end
`else
  assign ready = 1'b1;
`endif

  // State, counter, divisor and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state   <= DIS;
      cnt     <= '0;
      div     <= DIV_RST;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div     <= div_nxt;
      clk_out <= clk_nxt;
      tick    <= tick_nxt;
    end
  end

  // Next-state, counter and output decode; outputs are registered from cnt_nxt.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    clk_nxt   = 1'b0;
    tick_nxt  = 1'b0;
    div_nxt   = div;
`ifdef CLKDIV_GLITCHFREE_EN
    pvld_nxt  = pvld;
    pdiv_nxt  = pdiv;
`endif
    unique case (state)
      DIS: begin
        if (run_ok) begin
          state_nxt = RUN;
          clk_nxt   = 1'b1;
          tick_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (!run_ok) begin
          state_nxt = DIS;
        end else begin
          cnt_nxt  = last ? '0 : cnt + DIV_W'(1);
          clk_nxt  = 32'(cnt_nxt) < hi;
          tick_nxt = (cnt_nxt == '0);
        end
      end
      default: state_nxt = DIS;
    endcase

`ifdef CLKDIV_GLITCHFREE_EN
    if (pvld) begin
      if (state == DIS) begin
        // Hold off enabling until the new ratio is in place.
        div_nxt   = pdiv;
        pvld_nxt  = 1'b0;
        state_nxt = DIS;
        clk_nxt   = 1'b0;
        tick_nxt  = 1'b0;
      end else if (run_ok && last) begin
        div_nxt  = pdiv;
        pvld_nxt = 1'b0;
        if (pdiv < DIV_W'(DIV_MIN)) begin
          state_nxt = DIS;
          clk_nxt   = 1'b0;
          tick_nxt  = 1'b0;
        end
      end
    end
    if (wr) begin
      pvld_nxt = 1'b1;
      pdiv_nxt = wr_div;
    end
`else
    if (wr) begin
      // Immediate update restarts the period from cnt 0.
      div_nxt = wr_div;
      cnt_nxt = '0;
      if (en && (wr_div >= DIV_W'(DIV_MIN))) begin
        state_nxt = RUN;
        clk_nxt   = 1'b1;
        tick_nxt  = 1'b1;
      end else begin
        state_nxt = DIS;
        clk_nxt   = 1'b0;
        tick_nxt  = 1'b0;
      end
    end
`endif
  end

endmodule

// File: rtl/clk_divider_nch.sv
// NCH-channel programmable clock divider: config decode, cfg_ready mux and
// one clk_div_chan per channel. Optional feature macro: CLKDIV_GLITCHFREE_EN.
module clk_divider_nch
  import clk_div_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int DIV_W        = DIV_W_DEF,
  parameter int CLK_IN_FREQ  = 50_000_000,
  parameter int CLK_OUT_FREQ = 9600,
  localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_IN_FREQ / CLK_OUT_FREQ);

  logic [NCH-1:0]       rdy, wr;
  logic [2**CH_W-1:0]   rdy_ext;

  // Out-of-range channel indices always look ready so the write is dropped.
  for (genvar i = 0; i < 2**CH_W; i++) begin : g_rdy
    if (i < NCH) begin : g_in
      assign rdy_ext[i] = rdy[i];
    end else begin : g_out
      assign rdy_ext[i] = 1'b1;
    end
  end

  assign cfg_ready = rdy_ext[cfg_ch];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (ch_en[i]),
      .wr      (wr[i]),
      .wr_div  (cfg_div),
      .ready   (rdy[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_divider_nch.sv
// Directed bench for clk_divider_nch (default NCH=4, DIV_W=16, reset div 5208).
module tb_clk_divider_nch;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [3:0]  ch_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  int checks = 0;
  int errors = 0;

  clk_divider_nch dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int bad, hi, nt, n;
    rst = 1'b1; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    step(); step();
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    rst = 1'b0;
    step();

    // 1: reset divisor 5208 on ch0
    ch_en = 4'b0001;
    step();
    bad = 0; hi = 0; nt = 0;
    for (int k = 0; k < 2*5208; k++) begin
      if (k < 5208 && clk_out[0]) hi++;
      if (tick[0]) nt++;
      if (tick[0] !== (k % 5208 == 0)) bad++;
      if (clk_out[0] !== (k % 5208 < 2604)) bad++;
      step();
    end
    chk("t1_high_cycles", 32'(hi), 2604);
    chk("t1_tick_count", 32'(nt), 2);
    chk("t1_pattern_bad", 32'(bad), 0);
    ch_en = 4'b0000;
    step();

    // 2: odd divisor 5 on ch1 -> 1,1,1,0,0
    cfg_write(2'd1, 16'd5);
    ch_en[1] = 1'b1;
    step();
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (clk_out[1] !== (k % 5 < 3)) bad++;
      if (tick[1] !== (k % 5 == 0)) bad++;
      step();
    end
    chk("t2_odd_div_bad", 32'(bad), 0);

    // 3: illegal divisors 1 and 0 on ch2
    cfg_write(2'd2, 16'd1);
    ch_en[2] = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) bad++;
      step();
    end
    chk("t3_div1_bad", 32'(bad), 0);
    cfg_write(2'd2, 16'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) bad++;
      step();
    end
    chk("t3_div0_bad", 32'(bad), 0);

    // 4: ch3 div 8, drop enable at cnt 3, re-enable
    cfg_write(2'd3, 16'd8);
    ch_en[3] = 1'b1;
    step();
    chk("t4_start_tick", 32'(tick[3]), 1);
    step(); step(); step();
    chk("t4_cnt3_high", 32'(clk_out[3]), 1);
    chk("t4_cnt3_notick", 32'(tick[3]), 0);
    ch_en[3] = 1'b0;
    step();
    chk("t4_dis_clk", 32'(clk_out[3]), 0);
    chk("t4_dis_tick", 32'(tick[3]), 0);
    step(); step();
    ch_en[3] = 1'b1;
    step();
    chk("t4_reen_clk", 32'(clk_out[3]), 1);
    chk("t4_reen_tick", 32'(tick[3]), 1);

    // 5: ch0 div 10, change to 4 at cnt 2
    cfg_write(2'd0, 16'd10);
    ch_en[0] = 1'b1;
    step();
    step(); step();
    chk("t5_cnt2_high", 32'(clk_out[0]), 1);
    cfg_write(2'd0, 16'd4);
    bad = 0;
`ifdef CLKDIV_GLITCHFREE_EN
    for (int k = 0; k < 7; k++) begin
      if (clk_out[0] !== (3 + k < 5)) bad++;
      if (tick[0] !== 1'b0) bad++;
      if (cfg_ready !== 1'b0) bad++;
      step();
    end
    chk("t5_gf_tail_bad", 32'(bad), 0);
    bad = 0;
`endif
    for (int k = 0; k < 8; k++) begin
      if (clk_out[0] !== (k % 4 < 2)) bad++;
      if (tick[0] !== (k % 4 == 0)) bad++;
      if (cfg_ready !== 1'b1) bad++;
      step();
    end
    chk("t5_new_period_bad", 32'(bad), 0);

    // 6: async reset while ch1 high
    n = 0;
    while (clk_out[1] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t6_found_high", 32'(clk_out[1]), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_clk", 32'(clk_out), 0);
    chk("t6_async_tick", 32'(tick), 0);
    ch_en = '0;
    step();
    rst = 1'b0;
    step();
    ch_en[1] = 1'b1;
    step();
    chk("t6_restart_tick", 32'(tick[1]), 1);
    step();
    n = 1;
    while (tick[1] !== 1'b1 && n < 6000) begin
      step();
      n++;
    end
    chk("t6_reset_div_period", 32'(n), 5208);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
